// File: rtl/mod_lockin_accum.sv
// rtl/mod_lockin_accum.sv - lock-in demodulator accumulating signed ADC samples per reference window
`timescale 1ns/1ps

module mod_lockin_accum #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int NPER_W = 8
) (
  input  logic                     CLK_IN,
  input  logic                     RST,
  input  logic                     ENABLE,
  input  logic [NPER_W-1:0]        NUM_PERIODS,
  input  logic signed [DATA_W-1:0] ADC_DATA,
  input  logic                     ADC_VALID,
  input  logic                     CLK_OUT_MOD,
  input  logic                     CLK_OUT_MODN,
  input  logic                     CLK_OUT_MODL,
  output logic signed [ACC_W-1:0]  RESULT,
  output logic                     RESULT_VALID,
  output logic                     RESULT_SAT,
  output logic [15:0]              RESULT_NSAMP,
  output logic                     OVERLAP_ERR,
  output logic                     BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_INTEG} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [NPER_W-1:0]       NPER_ONE = NPER_W'(1);

  state_t state, state_nxt;

  // registered copies of the reference phases and the sample keep them aligned
  logic                     mod_q, modn_q, modl_q, modl_qq, valid_q;
  logic signed [DATA_W-1:0] data_q;

  logic signed [ACC_W-1:0]  acc;
  logic                     sat;
  logic [15:0]              nsamp;
  logic [NPER_W-1:0]        period_cnt;
  logic [NPER_W-1:0]        n_lat;

  logic                     mark_rise;
  logic                     samp_pos, samp_neg, samp_both;
  logic                     window_end;
  logic                     accum_en, restart, emit;
  logic [NPER_W-1:0]        n_new;
  logic signed [ACC_W-1:0]  base_acc;
  logic                     base_sat;
  logic [15:0]              base_nsamp;
  logic signed [ACC_W:0]    data_ext, contrib, sum_wide;
  logic                     ovf;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic                     sat_nxt;
  logic [15:0]              nsamp_nxt;

  // one-cycle input stage, plus the previous MODL value for edge detection
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      mod_q   <= 1'b0;
      modn_q  <= 1'b0;
      modl_q  <= 1'b0;
      modl_qq <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      mod_q   <= CLK_OUT_MOD;
      modn_q  <= CLK_OUT_MODN;
      modl_q  <= CLK_OUT_MODL;
      modl_qq <= modl_q;
      valid_q <= ADC_VALID;
      data_q  <= ADC_DATA;
    end
  end

  assign mark_rise = modl_q & ~modl_qq;
  assign samp_pos  = valid_q & mod_q & ~modn_q;
  assign samp_neg  = valid_q & modn_q & ~mod_q;
  assign samp_both = valid_q & mod_q & modn_q;
  assign n_new     = (NUM_PERIODS == '0) ? NPER_ONE : NUM_PERIODS;
  assign window_end = (({1'b0, period_cnt} + {{NPER_W{1'b0}}, 1'b1}) == {1'b0, n_lat});

  // a window opens on the first marker out of ARM and on every window end;
  // the coincident sample is always counted into the new window
  assign accum_en = ENABLE & ((state == S_INTEG) | ((state == S_ARM) & mark_rise));
  assign restart  = ENABLE & mark_rise & ((state == S_ARM) | ((state == S_INTEG) & window_end));
  assign emit     = ENABLE & mark_rise & (state == S_INTEG) & window_end;

  // saturating add/subtract one ACC_W+1 bits wide, so -2^(DATA_W-1) negates cleanly
  always_comb begin
    base_acc   = restart ? '0 : acc;
    base_sat   = restart ? 1'b0 : sat;
    base_nsamp = restart ? 16'd0 : nsamp;
    data_ext   = {{(ACC_W+1-DATA_W){data_q[DATA_W-1]}}, data_q};
    contrib    = '0;
    if (samp_pos) begin
      contrib = data_ext;
    end else if (samp_neg) begin
      contrib = -data_ext;
    end
    sum_wide = {base_acc[ACC_W-1], base_acc} + contrib;
    ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (ovf) begin
      acc_nxt = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_nxt = sum_wide[ACC_W-1:0];
    end
    sat_nxt = base_sat | ovf;
    if ((samp_pos | samp_neg) && (base_nsamp != 16'hFFFF)) begin
      nsamp_nxt = base_nsamp + 16'd1;
    end else begin
      nsamp_nxt = base_nsamp;
    end
  end

  // state register
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state: dropping ENABLE abandons any partial window
  always_comb begin
    state_nxt = state;
    if (!ENABLE) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_ARM;
        S_ARM:   state_nxt = mark_rise ? S_INTEG : S_ARM;
        S_INTEG: state_nxt = S_INTEG;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // state-decoded outputs
  always_comb begin
    BUSY = (state == S_INTEG);
  end

  // accumulator, period counting and the result register
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      acc          <= '0;
      sat          <= 1'b0;
      nsamp        <= 16'd0;
      period_cnt   <= '0;
      n_lat        <= '0;
      RESULT       <= '0;
      RESULT_VALID <= 1'b0;
      RESULT_SAT   <= 1'b0;
      RESULT_NSAMP <= 16'd0;
      OVERLAP_ERR  <= 1'b0;
    end else begin
      RESULT_VALID <= 1'b0;
      if (!ENABLE) begin
        OVERLAP_ERR <= 1'b0;
      end else if (accum_en && samp_both) begin
        OVERLAP_ERR <= 1'b1;
      end
      if (!ENABLE || (state == S_IDLE)) begin
        acc        <= '0;
        sat        <= 1'b0;
        nsamp      <= 16'd0;
        period_cnt <= '0;
      end else if (accum_en) begin
        acc   <= acc_nxt;
        sat   <= sat_nxt;
        nsamp <= nsamp_nxt;
        if (restart) begin
          period_cnt <= '0;
          n_lat      <= n_new;
        end else if (mark_rise) begin
          period_cnt <= period_cnt + NPER_ONE;
        end
      end
      if (emit) begin
        RESULT       <= acc;
        RESULT_SAT   <= sat;
        RESULT_NSAMP <= nsamp;
        RESULT_VALID <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mod_lockin_accum.sv
// tb/tb_mod_lockin_accum.sv - self-checking bench for mod_lockin_accum against a window-level model
`timescale 1ns/1ps

module tb_mod_lockin_accum;

  localparam int DW = 16;
  localparam int AW = 20;
  localparam int NW = 8;
  localparam longint AMAX = (longint'(1) << (AW-1)) - 1;
  localparam longint AMIN = -(longint'(1) << (AW-1));

  logic                 clk_in = 1'b0;
  logic                 rst, enable, adc_valid, clk_out_mod, clk_out_modn, clk_out_modl;
  logic [NW-1:0]        num_periods;
  logic signed [DW-1:0] adc_data;
  logic signed [AW-1:0] result;
  logic                 result_valid, result_sat, overlap_err, busy;
  logic [15:0]          result_nsamp;

  mod_lockin_accum #(.DATA_W(DW), .ACC_W(AW), .NPER_W(NW)) dut (
    .CLK_IN(clk_in), .RST(rst), .ENABLE(enable), .NUM_PERIODS(num_periods),
    .ADC_DATA(adc_data), .ADC_VALID(adc_valid),
    .CLK_OUT_MOD(clk_out_mod), .CLK_OUT_MODN(clk_out_modn), .CLK_OUT_MODL(clk_out_modl),
    .RESULT(result), .RESULT_VALID(result_valid), .RESULT_SAT(result_sat),
    .RESULT_NSAMP(result_nsamp), .OVERLAP_ERR(overlap_err), .BUSY(busy)
  );

  // free-running system clock
  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus controls
  int c_rst = 1, c_en = 0, c_nper = 4;
  int dmode = 0, vmode = 0, amp = 100, force_ovl = 0;
  int ph = 0, it = 0;
  bit prev_drv_modl = 0;

  // strobe log and marker log
  int     s_it[$];
  longint s_res[$];
  int     s_n[$];
  int     s_sat[$];
  int     rise_it[$];

  // reference model state
  int     m_mode = 0;
  longint m_sum = 0;
  int     m_sat = 0, m_n = 0, m_per = 0, m_nlat = 0;
  int     e_valid = 0, e_sat = 0, e_nsamp = 0, e_ovl = 0;
  longint e_result = 0;
  bit     p1_mod = 0, p1_modn = 0, p1_modl = 0, p1_valid = 0, p2_modl = 0;
  int     p1_data = 0;

  task automatic check_val(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (iter %0d)", tag, got, exp, it);
    end
  endtask

  task automatic clear_log();
    s_it.delete(); s_res.delete(); s_n.delete(); s_sat.delete(); rise_it.delete();
  endtask

  task automatic open_window();
    m_nlat = (num_periods == 0) ? 1 : int'(num_periods);
    m_per = 0; m_sum = 0; m_sat = 0; m_n = 0;
  endtask

  task automatic add_sample(input bit pos, input bit neg);
    longint s;
    if (!(pos || neg)) return;
    s = m_sum + (pos ? longint'(p1_data) : -longint'(p1_data));
    if (s > AMAX) begin s = AMAX; m_sat = 1; end
    else if (s < AMIN) begin s = AMIN; m_sat = 1; end
    m_sum = s;
    if (m_n < 65535) m_n++;
  endtask

  // one clock edge of the model: sees ENABLE now, and the phases/sample of the previous cycle
  task automatic model_update();
    bit mark, pos, neg, both;
    if (rst) begin
      m_mode = 0; m_sum = 0; m_sat = 0; m_n = 0; m_per = 0; m_nlat = 0;
      e_valid = 0; e_result = 0; e_sat = 0; e_nsamp = 0; e_ovl = 0;
      p1_mod = 0; p1_modn = 0; p1_modl = 0; p1_valid = 0; p1_data = 0; p2_modl = 0;
      return;
    end
    mark = p1_modl && !p2_modl;
    pos  = p1_valid && p1_mod && !p1_modn;
    neg  = p1_valid && p1_modn && !p1_mod;
    both = p1_valid && p1_mod && p1_modn;
    e_valid = 0;
    if (!enable) begin
      m_mode = 0; e_ovl = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (mark) begin
        open_window(); add_sample(pos, neg);
        if (both) e_ovl = 1;
        m_mode = 2;
      end
    end else begin
      if (both) e_ovl = 1;
      if (mark && (m_per + 1 == m_nlat)) begin
        e_valid = 1; e_result = m_sum; e_sat = m_sat; e_nsamp = m_n;
        open_window();
      end else if (mark) begin
        m_per++;
      end
      add_sample(pos, neg);
    end
    p2_modl = p1_modl;
    p1_mod = clk_out_mod; p1_modn = clk_out_modn; p1_modl = clk_out_modl;
    p1_valid = adc_valid; p1_data = int'(adc_data);
  endtask

  // one cycle: check outputs of the last edge, then drive the generator pattern for the next edge
  task automatic step();
    int r;
    @(negedge clk_in);
    check_val("result_valid", result_valid, e_valid);
    check_val("result", result, e_result);
    check_val("result_sat", result_sat, e_sat);
    check_val("result_nsamp", result_nsamp, e_nsamp);
    check_val("overlap_err", overlap_err, e_ovl);
    check_val("busy", busy, (m_mode == 2));
    if (result_valid === 1'b1) begin
      s_it.push_back(it); s_res.push_back(longint'(result));
      s_n.push_back(int'(result_nsamp)); s_sat.push_back(int'(result_sat));
    end
    rst = (c_rst != 0); enable = (c_en != 0); num_periods = NW'(c_nper);
    clk_out_mod  = (ph < 14);
    clk_out_modn = (ph >= 16) && (ph < 30);
    clk_out_modl = (ph < 16);
    if (force_ovl > 0 && clk_out_mod) begin
      clk_out_modn = 1'b1; force_ovl--;
    end
    case (dmode)
      0: adc_data = clk_out_mod ? DW'(amp) : (clk_out_modn ? DW'(-amp) : '0);
      1: adc_data = DW'(amp);
      default: begin
        r = $urandom_range(0, 9);
        if (r == 0) adc_data = 16'sh8000;
        else if (r == 1) adc_data = 16'sh7FFF;
        else adc_data = DW'($urandom);
      end
    endcase
    case (vmode)
      0: adc_valid = 1'b1;
      1: adc_valid = (it % 2 == 0);
      default: adc_valid = ($urandom_range(0, 3) != 0);
    endcase
    if (clk_out_modl && !prev_drv_modl && c_en != 0 && c_rst == 0) rise_it.push_back(it);
    prev_drv_modl = clk_out_modl;
    model_update();
    ph = (ph + 1) % 32;
    it++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_ph(input int p);
    for (int i = 0; i < 32 && ph != p; i++) step();
  endtask

  initial begin
    int last;
    rst = 1'b1; enable = 1'b0; num_periods = '0; adc_data = '0; adc_valid = 1'b0;
    clk_out_mod = 1'b0; clk_out_modn = 1'b0; clk_out_modl = 1'b0;

    // reset state
    run(3);
    check_val("rst_result", result, 0);
    check_val("rst_valid", result_valid, 0);
    check_val("rst_busy", busy, 0);
    c_rst = 0;
    run(5);

    // S1: +/-100 demodulated, N=4
    clear_log();
    c_en = 1;
    run(128 * 6);
    check_val("s1_nstrobe_ok", s_it.size() >= 2, 1);
    if (s_it.size() >= 2 && rise_it.size() >= 5) begin
      check_val("s1_first_latency", s_it[0], rise_it[4] + 2);
      check_val("s1_spacing", s_it[1] - s_it[0], 128);
      check_val("s1_result", s_res[0], 11200);
      check_val("s1_nsamp", s_n[0], 112);
      check_val("s1_sat", s_sat[0], 0);
    end

    // S2: constant +100 averages out, windows stay back-to-back
    wait_ph(0);
    dmode = 1;
    clear_log();
    run(128 * 3);
    check_val("s2_nstrobe_ok", s_it.size() >= 2, 1);
    if (s_it.size() >= 2) begin
      last = s_it.size() - 1;
      check_val("s2_result", s_res[last], 0);
      check_val("s2_nsamp", s_n[last], 112);
      check_val("s2_spacing", s_it[last] - s_it[last-1], 128);
    end

    // S3: saturation with N=1, then recovery in the next window
    c_en = 0; run(2);
    c_nper = 1; dmode = 0; amp = 32767;
    wait_ph(8);
    c_en = 1;
    clear_log();
    wait_ph(0);
    run(32);
    amp = 1;
    run(70);
    check_val("s3_nstrobe_ok", s_it.size() >= 2, 1);
    if (s_it.size() >= 2) begin
      check_val("s3_sat_result", s_res[0], 524287);
      check_val("s3_sat_flag", s_sat[0], 1);
      check_val("s3_sat_nsamp", s_n[0], 28);
      check_val("s3_small_result", s_res[1], 28);
      check_val("s3_small_sat", s_sat[1], 0);
    end

    // S4: three overlapping cycles are excluded and flagged
    c_en = 0; run(2);
    amp = 100;
    wait_ph(8);
    c_en = 1;
    clear_log();
    wait_ph(0);
    run(4);
    force_ovl = 3;
    run(28);
    run(3);
    check_val("s4_nstrobe_ok", s_it.size() >= 1, 1);
    if (s_it.size() >= 1) begin
      check_val("s4_nsamp", s_n[0], 25);
      check_val("s4_result", s_res[0], 2500);
    end
    check_val("s4_ovl_set", overlap_err, 1);
    run(40);
    check_val("s4_ovl_sticky", overlap_err, 1);
    c_en = 0; step(); step();
    check_val("s4_ovl_clear", overlap_err, 0);

    // S5: ENABLE dropped in period 2 of 4, then re-enabled
    c_nper = 4;
    wait_ph(8);
    c_en = 1;
    clear_log();
    wait_ph(0);
    run(48);
    c_en = 0; step(); step();
    check_val("s5_busy_drop", busy, 0);
    run(150);
    check_val("s5_no_strobe", s_it.size(), 0);
    clear_log();
    wait_ph(8);
    c_en = 1;
    run(32 * 5 + 10);
    check_val("s5_nstrobe_ok", (s_it.size() >= 1) && (rise_it.size() >= 1), 1);
    if (s_it.size() >= 1 && rise_it.size() >= 1) begin
      check_val("s5_restart_latency", s_it[0], rise_it[0] + 128 + 2);
      check_val("s5_result", s_res[0], 11200);
    end

    // S6: reset mid-window with ADC_VALID on every other cycle
    vmode = 1;
    wait_ph(20);
    c_rst = 1;
    run(3);
    check_val("s6_rst_result", result, 0);
    check_val("s6_rst_valid", result_valid, 0);
    check_val("s6_rst_sat", result_sat, 0);
    check_val("s6_rst_nsamp", result_nsamp, 0);
    check_val("s6_rst_ovl", overlap_err, 0);
    check_val("s6_rst_busy", busy, 0);
    c_rst = 0;
    clear_log();
    run(128 * 2 + 64);
    check_val("s6_nstrobe_ok", s_it.size() >= 1, 1);
    if (s_it.size() >= 1) begin
      check_val("s6_nsamp", s_n[0], 56);
      check_val("s6_result", s_res[0], 5600);
    end

    // S7: random data, valid, period counts, overlaps and enable drops against the model
    dmode = 2; vmode = 2;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) c_en = 0;
      else if (c_en == 0 && $urandom_range(0, 19) == 0) c_en = 1;
      if ($urandom_range(0, 199) == 0) c_nper = $urandom_range(0, 2);
      if ($urandom_range(0, 299) == 0) force_ovl = $urandom_range(1, 4);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
